mux_pam_tdm: RTL and testbench



---
 rtl/mux_pam_tdm.sv | 126 ++++++++++++
 tb/tb_mux_pam_tdm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pam_tdm.sv
// Time-division PAM word mux: captures a Depth-word frame over valid/ready and
// plays it out one slot at a time, either scanning all indices or repeating one.
module mux_pam_tdm #(
  parameter int Width = 64,
  parameter int Depth = 4,
  parameter int HoldW = 8,
  localparam int IdxW = $clog2(Depth)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] INPUTS [Depth],
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             MODE,
  input  logic [IdxW-1:0]  SEL,
  input  logic [HoldW-1:0] HOLD,
  output logic [Width-1:0] OUT,
  output logic             OUT_VALID,
  output logic [IdxW-1:0]  OUT_IDX,
  output logic             FRAME_DONE
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

  state_t           state_q, state_d;
  logic [Width-1:0] frame_q [Depth];
  logic [Width-1:0] frame_d [Depth];
  logic             mode_q, mode_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [HoldW-1:0] slot_q, slot_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [Width-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic [IdxW-1:0]  first_idx;
  logic [IdxW-1:0]  next_idx;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    mode_d   = mode_q;
    hold_d   = hold_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    out_d    = out_q;
    valid_d  = valid_q;
    done_d   = done_q;
    accept   = IN_VALID && ready_q;
    next_idx = IdxW'(idx_q + 1'b1);
    // Out-of-range manual selects (non-power-of-two Depth) fall back to word 0.
    if (MODE || int'(SEL) >= Depth) begin
      first_idx = '0;
    end else begin
      first_idx = SEL;
    end

    if (accept) begin
      state_d = SEND;
      frame_d = INPUTS;
      mode_d  = MODE;
      hold_d  = HOLD;
      slot_d  = '0;
      idx_d   = first_idx;
      out_d   = INPUTS[first_idx];
      valid_d = 1'b1;
      done_d  = (HOLD == '0) && !MODE;
    end else if (state_q == SEND) begin
      if (done_q) begin
        state_d = IDLE;
        slot_d  = '0;
        idx_d   = '0;
        out_d   = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end else if (slot_q == hold_q) begin
        slot_d = '0;
        idx_d  = next_idx;
        out_d  = frame_q[next_idx];
        done_d = (hold_q == '0) && (next_idx == LastIdx);
      end else begin
        slot_d = slot_q + 1'b1;
        done_d = (slot_d == hold_q) && (!mode_q || idx_q == LastIdx);
      end
    end
    // Ready is registered alongside the outputs so it holds low through reset.
    ready_d = (state_d == IDLE) || done_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      for (int i = 0; i < Depth; i++) frame_q[i] <= '0;
      mode_q  <= 1'b0;
      hold_q  <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign IN_READY   = ready_q;
  assign OUT        = out_q;
  assign OUT_VALID  = valid_q;
  assign OUT_IDX    = idx_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_mux_pam_tdm.sv
// Bench for mux_pam_tdm: a queue-based frame model checked every cycle, plus
// directed literal expectations and a Depth=3 instance for the select fallback.
module tb_mux_pam_tdm;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inw [4];
  logic        in_valid, in_ready, mode;
  logic [1:0]  sel;
  logic [7:0]  hold;
  logic [63:0] out_w;
  logic        out_valid, frame_done;
  logic [1:0]  out_idx;

  logic [63:0] inw3 [3];
  logic        in_valid3, in_ready3, mode3;
  logic [1:0]  sel3;
  logic [7:0]  hold3;
  logic [63:0] out3;
  logic        out_valid3, frame_done3;
  logic [1:0]  out_idx3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_pam_tdm dut (
    .CLK(clk), .RST(rst), .INPUTS(inw), .IN_VALID(in_valid), .IN_READY(in_ready),
    .MODE(mode), .SEL(sel), .HOLD(hold), .OUT(out_w), .OUT_VALID(out_valid),
    .OUT_IDX(out_idx), .FRAME_DONE(frame_done)
  );

  mux_pam_tdm #(.Width(64), .Depth(3), .HoldW(8)) dut3 (
    .CLK(clk), .RST(rst), .INPUTS(inw3), .IN_VALID(in_valid3), .IN_READY(in_ready3),
    .MODE(mode3), .SEL(sel3), .HOLD(hold3), .OUT(out3), .OUT_VALID(out_valid3),
    .OUT_IDX(out_idx3), .FRAME_DONE(frame_done3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Model: one queue entry per future output cycle; the front is what is on OUT now.
  typedef struct {
    logic [63:0] w;
    int          idx;
    bit          done;
  } ent_t;
  ent_t mq[$];
  bit   m_ready = 1'b0;

  always @(posedge clk) begin
    bit   acc;
    int   slots;
    int   h;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ready = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        slots = mode ? 4 : 1;
        h     = int'(hold) + 1;
        for (int s = 0; s < slots; s++) begin
          for (int k = 0; k < h; k++) begin
            e.idx  = mode ? s : ((int'(sel) < 4) ? int'(sel) : 0);
            e.w    = inw[e.idx];
            e.done = (s == slots - 1) && (k == h - 1);
            mq.push_back(e);
          end
        end
      end
      m_ready = (mq.size() <= 1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ready", {63'd0, in_ready}, {63'd0, m_ready});
      if (mq.size() > 0) begin
        chk("model_out", out_w, mq[0].w);
        chk("model_valid", {63'd0, out_valid}, 64'd1);
        chk("model_idx", {62'd0, out_idx}, 64'(mq[0].idx));
        chk("model_done", {63'd0, frame_done}, {63'd0, mq[0].done});
      end else begin
        chk("model_idle_out", out_w, 64'd0);
        chk("model_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("model_idle_idx", {62'd0, out_idx}, 64'd0);
        chk("model_idle_done", {63'd0, frame_done}, 64'd0);
      end
    end
  end

  task automatic set_frame(input logic [63:0] a, b, c, d);
    inw[0] = a; inw[1] = b; inw[2] = c; inw[3] = d;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b1; sel = 2'd0; hold = 8'd0;
    set_frame(64'd300, 64'd299, 64'd298, 64'd297);
    in_valid3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; hold3 = 8'd0;
    inw3[0] = 64'd11; inw3[1] = 64'd22; inw3[2] = 64'd33;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out", out_w, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Auto scan, HOLD=0
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_out", out_w, 64'(300 - k));
      chk("t1_idx", {62'd0, out_idx}, 64'(k));
      chk("t1_done", {63'd0, frame_done}, {63'd0, k == 3});
      @(negedge clk);
    end
    chk("t1_idle_valid", {63'd0, out_valid}, 64'd0);
    chk("t1_idle_out", out_w, 64'd0);

    // Auto scan, HOLD=2
    hold = 8'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("t2_out", out_w, 64'(300 - c / 3));
      chk("t2_ready", {63'd0, in_ready}, {63'd0, c == 11});
      @(negedge clk);
    end
    chk("t2_idle_valid", {63'd0, out_valid}, 64'd0);

    // Manual SEL=2, HOLD=1; SEL change mid-slot ignored
    mode = 1'b0; sel = 2'd2; hold = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_out0", out_w, 64'd298);
    chk("t3_idx0", {62'd0, out_idx}, 64'd2);
    chk("t3_done0", {63'd0, frame_done}, 64'd0);
    sel = 2'd3; inw[2] = 64'd5555;
    @(negedge clk);
    chk("t3_out1", out_w, 64'd298);
    chk("t3_done1", {63'd0, frame_done}, 64'd1);
    @(negedge clk);
    chk("t3_idle_valid", {63'd0, out_valid}, 64'd0);

    // Back-to-back auto frames A then B
    mode = 1'b1; hold = 8'd0; sel = 2'd0;
    set_frame(64'd1, 64'd2, 64'd3, 64'd4);
    in_valid = 1'b1;
    @(negedge clk);
    set_frame(64'd5, 64'd6, 64'd7, 64'd8);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) in_valid = 1'b0;
      chk("t4_out", out_w, 64'(c + 1));
      chk("t4_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_done", {63'd0, frame_done}, {63'd0, c == 3 || c == 7});
      @(negedge clk);
    end
    chk("t4_idle_valid", {63'd0, out_valid}, 64'd0);

    // Manual HOLD=0 streaming: ready every cycle
    mode = 1'b0; sel = 2'd1; hold = 8'd0; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_frame(64'(100 + c), 64'(200 + c), 64'd0, 64'd0);
      @(negedge clk);
      chk("t5_ready", {63'd0, in_ready}, 64'd1);
      chk("t5_out", out_w, 64'(200 + c));
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset mid-frame
    mode = 1'b1; hold = 8'd0;
    set_frame(64'd300, 64'd299, 64'd298, 64'd297);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_out_pre", out_w, 64'd299);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", out_w, 64'd0);
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_done", {63'd0, frame_done}, 64'd0);
    rst = 1'b0;
    set_frame(64'd9, 64'd8, 64'd7, 64'd6);
    in_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_new_out", out_w, 64'd9);
    chk("t6_new_idx", {62'd0, out_idx}, 64'd0);
    repeat (5) @(negedge clk);

    // Depth=3: out-of-range manual select falls back to word 0
    mode3 = 1'b0; sel3 = 2'd3; hold3 = 8'd0; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    chk("d3_out", out3, 64'd11);
    chk("d3_idx", {62'd0, out_idx3}, 64'd0);
    chk("d3_valid", {63'd0, out_valid3}, 64'd1);
    chk("d3_done", {63'd0, frame_done3}, 64'd1);
    @(negedge clk);
    sel3 = 2'd2; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    chk("d3_sel2_out", out3, 64'd33);
    chk("d3_sel2_idx", {62'd0, out_idx3}, 64'd2);
    @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
